// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential radix-2 multiply/divide unit with pipeline stall handshake
module mdu_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

    state_t         state, state_nxt;
    logic [4:0]     cnt;
    logic           is_div, neg_res, neg_rem;
    logic [W-1:0]   opb;
    // mul: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
    logic [2*W-1:0] acc;

    logic           accept, div_zero, sgn;
    logic [W-1:0]   abs_a, abs_b;
    logic [W:0]     mul_upper, div_shift;
    logic [2*W-1:0] mul_next, div_next, prod_neg;
    logic [W-1:0]   div_diff, fix_hi, fix_lo;
    logic           div_ge;

    assign accept   = (state == IDLE) && start_i && !flush_i;
    assign div_zero = op_i[1] && (reg2_i == '0);
    assign sgn      = !op_i[0];
    assign abs_a    = (sgn && reg1_i[W-1]) ? -reg1_i : reg1_i;
    assign abs_b    = (sgn && reg2_i[W-1]) ? -reg2_i : reg2_i;

    // Shift-add step: add multiplicand to the upper half when the multiplier LSB is set
    assign mul_upper = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opb : '0)};
    assign mul_next  = {mul_upper, acc[W-1:1]};

    // Restoring divide step: remainder stays below the divisor, so the difference fits W bits
    assign div_shift = {acc[2*W-1:W], acc[W-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_diff  = div_shift[W-1:0] - opb;
    assign div_next  = div_ge ? {div_diff, acc[W-2:0], 1'b1}
                              : {div_shift[W-1:0], acc[W-2:0], 1'b0};

    assign prod_neg = -acc;

    always_comb begin
        fix_hi = acc[2*W-1:W];
        fix_lo = acc[W-1:0];
        if (is_div) begin
            if (neg_rem) fix_hi = -acc[2*W-1:W];
            if (neg_res) fix_lo = -acc[W-1:0];
        end else if (neg_res) begin
            fix_hi = prod_neg[2*W-1:W];
            fix_lo = prod_neg[W-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_i) state_nxt = div_zero ? DONE : BUSY;
                BUSY:    if (cnt == 5'd31) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_o = 1'b0;
        stall_o = 1'b0;
        if (!rst_i) begin
            valid_o = (state == DONE) && !flush_i;
            stall_o = accept || (state == BUSY) || (state == FIX);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opb     <= '0;
            acc     <= '0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else if (accept) begin
            cnt     <= '0;
            is_div  <= op_i[1];
            neg_res <= sgn && (reg1_i[W-1] ^ reg2_i[W-1]);
            neg_rem <= sgn && reg1_i[W-1];
            opb     <= op_i[1] ? abs_b : abs_a;
            acc     <= {{W{1'b0}}, (op_i[1] ? abs_a : abs_b)};
            if (div_zero) begin
                hi_o <= reg1_i;
                lo_o <= '1;
            end
        end else if (!flush_i && state == BUSY) begin
            cnt <= cnt + 5'd1;
            acc <= is_div ? div_next : mul_next;
        end else if (!flush_i && state == FIX) begin
            hi_o <= fix_hi;
            lo_o <= fix_lo;
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - scoreboard bench for mdu_seq
module tb_mdu_seq;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] reg1_i = '0;
    logic [31:0] reg2_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, valid_o;
    logic [31:0] hi_o, lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mdu_seq #(.DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb;
        logic [31:0] q, r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        case (op)
            2'd0: return sa * sb;
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = qa / qb;
                r = qa % qb;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(negedge clk_i) begin
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 64'(valid_o), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("latency", 64'(cyc), 64'(e.due));
                check("hi", 64'(hi_o), 64'(e.hi));
                check("lo", 64'(lo_o), 64'(e.lo));
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
            exp_t e;
            e = exp_q.pop_front();
            check("missing_valid", 64'(valid_o), 64'd1);
        end
    end

    task automatic issue_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] hi, input logic [31:0] lo, input bit chk_stall);
        exp_t e;
        bit   dz;
        dz = op[1] && (b == 0);
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = op; reg1_i = a; reg2_i = b;
        e.hi = hi; e.lo = lo; e.due = cyc + (dz ? 1 : 34);
        exp_q.push_back(e);
        @(negedge clk_i);
        if (chk_stall) check("stall_accept", 64'(stall_o), 64'd1);
        @(posedge clk_i); #2;
        start_i = 1'b0;
        if (chk_stall) begin
            for (int k = 1; k <= 34; k++) begin
                @(negedge clk_i);
                check($sformatf("stall_t%0d", k), 64'(stall_o), (k < 34) ? 64'd1 : 64'd0);
                if (k < 34) @(posedge clk_i);
            end
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = model(op, a, b);
        issue_exp(op, a, b, r[63:32], r[31:0], 1'b0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            check("result_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;

        issue_exp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        wait_done();
        issue_exp(2'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        wait_done();
        issue_exp(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done();
        issue_exp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        wait_done();
        issue_exp(2'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
        wait_done();

        for (int i = 0; i < 12; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(op, a, b);
            wait_done();
        end

        // Flush in the 10th BUSY cycle, then a fresh request must still go through
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = 2'd1; reg1_i = 32'd1000; reg2_i = 32'd2000;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #2 flush_i = 1'b1;
        @(posedge clk_i); #2;
        flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_stall", 64'(stall_o), 64'd0);
        repeat (40) @(negedge clk_i);
        issue_exp(2'd1, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
        wait_done();

        // Reset mid-BUSY aborts; a start right after reset is accepted
        @(posedge clk_i); #2;
        start_i = 1'b1; op_i = 2'd0; reg1_i = 32'h1234_5678; reg2_i = 32'h0000_0321;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        repeat (15) @(posedge clk_i);
        #2 rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("midrst_valid", 64'(valid_o), 64'd0);
        check("midrst_stall", 64'(stall_o), 64'd0);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;
        issue(2'd3, 32'd1_000_003, 32'd17);
        wait_done();

        // start_i held high with new operands while busy must not disturb the result
        begin
            exp_t        e;
            logic [63:0] r;
            r = model(2'd1, 32'h0001_E240, 32'h0000_162E);
            @(posedge clk_i); #2;
            start_i = 1'b1; op_i = 2'd1; reg1_i = 32'h0001_E240; reg2_i = 32'h0000_162E;
            e.hi = r[63:32]; e.lo = r[31:0]; e.due = cyc + 34;
            exp_q.push_back(e);
            for (int k = 1; k <= 33; k++) begin
                @(posedge clk_i); #2;
                op_i = 2'($urandom_range(0, 3)); reg1_i = $urandom; reg2_i = $urandom;
            end
            @(posedge clk_i); #2;
            start_i = 1'b0;
            wait_done();
        end

        repeat (5) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
